// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with registered read port
// Flags decode the occupancy register; overflow/underflow are sticky until cleared.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_buffer_in,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  input  logic                     i_clr_err,
  output logic [WIDTH-1:0]         o_buffer_out,
  output logic                     o_out_valid,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_almost_empty,
  output logic                     o_almost_full,
  output logic                     o_overflow,
  output logic                     o_underflow,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_buffer_out;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_empty;
  logic             w_full;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_wr_ok = i_wr_en & ~w_full;
  assign w_rd_ok = i_rd_en & ~w_empty;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_buffer_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_buffer_out <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_out_valid <= w_rd_ok;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_buffer_out <= r_mem[r_rd_ptr];
        r_rd_ptr     <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A fresh error event takes priority over a coincident clear.
      if (i_wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (i_rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (i_clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_buffer_out   = r_buffer_out;
  assign o_out_valid    = r_out_valid;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_empty = (r_count <= CW'(AE_LEVEL));
  assign o_almost_full  = (r_count >= CW'(AF_LEVEL));
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_count        = r_count;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed checks on an 8x8 FIFO plus random traffic on a 32x16 FIFO
// Both instances are compared every cycle against queue-based reference models.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, wr_a, rd_a, clr_a;
  logic [7:0]  din_a, out_a;
  logic        val_a, emp_a, ful_a, ae_a, af_a, ov_a, uf_a;
  logic [3:0]  cnt_a;

  logic        rst_b, wr_b, rd_b, clr_b;
  logic [31:0] din_b, out_b;
  logic        val_b, emp_b, ful_b, ae_b, af_b, ov_b, uf_b;
  logic [4:0]  cnt_b;

  fifo_sync_param u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_buffer_in(din_a), .i_wr_en(wr_a), .i_rd_en(rd_a),
    .i_clr_err(clr_a), .o_buffer_out(out_a), .o_out_valid(val_a), .o_empty(emp_a),
    .o_full(ful_a), .o_almost_empty(ae_a), .o_almost_full(af_a), .o_overflow(ov_a),
    .o_underflow(uf_a), .o_count(cnt_a)
  );

  fifo_sync_param #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_buffer_in(din_b), .i_wr_en(wr_b), .i_rd_en(rd_b),
    .i_clr_err(clr_b), .o_buffer_out(out_b), .o_out_valid(val_b), .o_empty(emp_b),
    .o_full(ful_b), .o_almost_empty(ae_b), .o_almost_full(af_b), .o_overflow(ov_b),
    .o_underflow(uf_b), .o_count(cnt_b)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  logic [7:0]  qa[$];
  logic [7:0]  ea_out;
  logic        ea_val, ea_ov, ea_uf;
  logic [31:0] qb[$];
  logic [31:0] eb_out;
  logic        eb_val, eb_ov, eb_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_a();
    bit full, empty;
    full  = (qa.size() == 8);
    empty = (qa.size() == 0);
    if (!rst_a) begin
      qa.delete();
      ea_out = '0; ea_val = 1'b0; ea_ov = 1'b0; ea_uf = 1'b0;
    end else begin
      ea_val = rd_a && !empty;
      if (ea_val) ea_out = qa.pop_front();
      if (wr_a && !full) qa.push_back(din_a);
      ea_ov = (wr_a && full)  ? 1'b1 : (clr_a ? 1'b0 : ea_ov);
      ea_uf = (rd_a && empty) ? 1'b1 : (clr_a ? 1'b0 : ea_uf);
    end
  endtask

  task automatic model_b();
    bit full, empty;
    full  = (qb.size() == 16);
    empty = (qb.size() == 0);
    if (!rst_b) begin
      qb.delete();
      eb_out = '0; eb_val = 1'b0; eb_ov = 1'b0; eb_uf = 1'b0;
    end else begin
      eb_val = rd_b && !empty;
      if (eb_val) eb_out = qb.pop_front();
      if (wr_b && !full) qb.push_back(din_b);
      eb_ov = (wr_b && full)  ? 1'b1 : (clr_b ? 1'b0 : eb_ov);
      eb_uf = (rd_b && empty) ? 1'b1 : (clr_b ? 1'b0 : eb_uf);
    end
  endtask

  task automatic check_a();
    chk("a_count", 32'(cnt_a), qa.size());
    chk("a_empty", 32'(emp_a), 32'(qa.size() == 0));
    chk("a_full",  32'(ful_a), 32'(qa.size() == 8));
    chk("a_aempty", 32'(ae_a), 32'(qa.size() <= 2));
    chk("a_afull",  32'(af_a), 32'(qa.size() >= 6));
    chk("a_overflow",  32'(ov_a), 32'(ea_ov));
    chk("a_underflow", 32'(uf_a), 32'(ea_uf));
    chk("a_out_valid", 32'(val_a), 32'(ea_val));
    chk("a_buffer_out", 32'(out_a), 32'(ea_out));
  endtask

  task automatic check_b();
    chk("b_count", 32'(cnt_b), qb.size());
    chk("b_empty", 32'(emp_b), 32'(qb.size() == 0));
    chk("b_full",  32'(ful_b), 32'(qb.size() == 16));
    chk("b_aempty", 32'(ae_b), 32'(qb.size() <= 3));
    chk("b_afull",  32'(af_b), 32'(qb.size() >= 12));
    chk("b_overflow",  32'(ov_b), 32'(eb_ov));
    chk("b_underflow", 32'(uf_b), 32'(eb_uf));
    chk("b_out_valid", 32'(val_b), 32'(eb_val));
    chk("b_buffer_out", out_b, eb_out);
  endtask

  // Instance B gets fresh random traffic each cycle, alternating fill-biased and drain-biased phases.
  task automatic tick();
    bit fill_phase;
    fill_phase = ((cyc / 40) % 2) == 0;
    wr_b  = ($urandom % 4) < (fill_phase ? 3 : 1);
    rd_b  = ($urandom % 4) < (fill_phase ? 1 : 3);
    din_b = $urandom;
    clr_b = ($urandom % 16) == 0;
    @(posedge clk);
    #1;
    model_a();
    model_b();
    check_a();
    check_b();
    cyc++;
  endtask

  task automatic op_a(input bit w, input bit r, input logic [7:0] d, input bit c);
    wr_a = w; rd_a = r; din_a = d; clr_a = c;
    tick();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0; din_a = '0;
    wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0; din_b = '0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    model_a(); model_b();
    check_a(); check_b();
    @(posedge clk);
    #1;
    rst_a = 1'b1; rst_b = 1'b1;

    for (int i = 0; i < 8; i++) op_a(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    chk("fill_count", 32'(cnt_a), 8);
    chk("fill_full", 32'(ful_a), 1);

    op_a(1'b1, 1'b0, 8'hAA, 1'b0);
    chk("ovf_set", 32'(ov_a), 1);
    chk("ovf_count", 32'(cnt_a), 8);
    op_a(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(ov_a), 0);

    for (int i = 0; i < 8; i++) begin
      op_a(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_data", 32'(out_a), 32'(8'h10 + i));
      chk("drain_valid", 32'(val_a), 1);
    end
    chk("drain_empty", 32'(emp_a), 1);

    op_a(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_set", 32'(uf_a), 1);
    chk("udf_valid", 32'(val_a), 0);
    chk("udf_hold", 32'(out_a), 32'h17);
    op_a(1'b0, 1'b0, 8'h00, 1'b1);

    op_a(1'b1, 1'b1, 8'h30, 1'b0);
    chk("sim_empty_count", 32'(cnt_a), 1);
    chk("sim_empty_udf", 32'(uf_a), 1);
    op_a(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 1; i < 4; i++) op_a(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      op_a(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
      chk("sim_mid_count", 32'(cnt_a), 4);
      chk("sim_mid_data", 32'(out_a), (i < 4) ? 32'(8'h30 + i) : 32'(8'h40 + i - 4));
    end

    for (int i = 0; i < 4; i++) op_a(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
    chk("refill_full", 32'(ful_a), 1);
    op_a(1'b1, 1'b1, 8'h60, 1'b0);
    chk("sim_full_count", 32'(cnt_a), 7);
    chk("sim_full_ovf", 32'(ov_a), 1);
    chk("sim_full_data", 32'(out_a), 32'h50);

    op_a(1'b0, 1'b1, 8'h00, 1'b0);
    op_a(1'b0, 1'b1, 8'h00, 1'b0);
    chk("pre_rst_count", 32'(cnt_a), 5);
    chk("pre_rst_valid", 32'(val_a), 1);

    #2;
    rst_a = 1'b0;
    #1;
    chk("async_rst_count", 32'(cnt_a), 0);
    chk("async_rst_empty", 32'(emp_a), 1);
    chk("async_rst_out", 32'(out_a), 0);
    chk("async_rst_valid", 32'(val_a), 0);
    chk("async_rst_ovf", 32'(ov_a), 0);
    model_a();
    op_a(1'b0, 1'b0, 8'h00, 1'b0);
    rst_a = 1'b1;
    op_a(1'b1, 1'b0, 8'h99, 1'b0);
    op_a(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_data", 32'(out_a), 32'h99);

    for (int i = 0; i < 400; i++) op_a(1'b0, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
